button_debouncer: RTL and testbench
===================================

# button_debouncer

Conditions one raw, asynchronous push-button input into a clean debounced level plus single-cycle press, release and long-press strobes. It sits directly upstream of `edge_to_pulse` and the UI/menu logic. `btn_level` or any strobe can drive `edge_in` without chatter reaching downstream stages.

## Interface
- `CLK_HZ`, 27000000, clock frequency in Hz
- `DEBOUNCE_MS`, 20, time the synchronized input must hold a new value before `btn_level` follows
- `LONG_PRESS_MS`, 1000, press duration that fires `long_stb`
- `ACTIVE_LEVEL`, 1'b0, raw pin level meaning "pressed" (buttons are pulled up, so active-low)

Ports:
- `clk` input 1, clock
- `rstn` input 1, reset. Synchronous, active-low; clock `clk`.
- `btn_in` input 1, raw pin, asynchronous to `clk`, may bounce
- `btn_level` output 1, debounced state; 1 = pressed, independent of `ACTIVE_LEVEL`
- `press_stb` output 1, one-cycle pulse on the debounced press
- `release_stb` output 1, one-cycle pulse on the debounced release
- `long_stb` output 1, one-cycle pulse, at most once per press, when the press reaches `LONG_PRESS_MS`
- `long_held` output 1, high from `long_stb` until release

## Operation
- Constants:
  - `DEB_TC = max(1, CLK_HZ/1000*DEBOUNCE_MS)`
  - `LONG_TC = max(1, CLK_HZ/1000*LONG_PRESS_MS)`
  - All counters are 32-bit unsigned. Compute the product at elaboration and saturate nothing at run time.
- Synchronizer: two flops, `s1 <= btn_in`, `s2 <= s1`.
  - Normalized input is `p = (s2 == ACTIVE_LEVEL)`.
  - Both flops reset to `~ACTIVE_LEVEL`, so a reset reads as not pressed.
- Debounce counter `deb_cnt`, updated every cycle:
  - If `p == btn_level`: `deb_cnt <= 0`.
  - Else if `deb_cnt == DEB_TC-1`: `btn_level <= p` and `deb_cnt <= 0`.
  - Else: `deb_cnt <= deb_cnt+1`.
  - Any cycle with `p` equal to the current level restarts the count, which rejects bounces shorter than `DEB_TC` cycles.
- FSM states: RELEASED, PRESSED, HELD.
  - RELEASED → PRESSED when the debounce commits a press. `press_stb=1` for that cycle and `hold_cnt <= 0`.
  - PRESSED: `hold_cnt` increments each cycle.
    - At `hold_cnt == LONG_TC-1`: go to HELD, `long_stb=1` for one cycle, `long_held <= 1`.
    - A debounced release goes to RELEASED with `release_stb=1`.
  - HELD: a debounced release goes to RELEASED with `release_stb=1` and `long_held <= 0`.
- Simultaneous events: if a release commits in the same cycle `hold_cnt` reaches `LONG_TC-1`, the release wins. Fire `release_stb`, not `long_stb`.
- All outputs are registered. The strobes are never high together.

## Timing
- Reset values: `btn_level=0`, `press_stb=0`, `release_stb=0`, `long_stb=0`, `long_held=0`, state RELEASED, `deb_cnt=0`, `hold_cnt=0`, `s1=s2=~ACTIVE_LEVEL`.
- Latency: raw input stable from sampling edge k gives `btn_level` and the strobe at the output after edge k+1+DEB_TC.
- `long_stb` is asserted exactly `LONG_TC` cycles after the `press_stb` cycle.
- Reset mid-operation:
  - Everything clears on the next edge with `rstn=0`, and no strobe is emitted for the aborted press.
  - A button still held after reset deasserts re-registers as a fresh press, DEB_TC+2 cycles after the first edge with `rstn=1`.
- Metastability: only `s1` samples `btn_in`. No other logic reads `btn_in` or `s1`.

## Structure
- Sub-module `sync_2ff`: 2-flop synchronizer with a reset-value parameter. It is reused by other async inputs.
- No shared package. State encodings and `DEB_TC`/`LONG_TC` are local constants.
- Debounce counter and FSM live in one always block each.

## Test plan
Bench parameters: `CLK_HZ=1000` (1 cycle/ms), `DEBOUNCE_MS=4`, `LONG_PRESS_MS=10`, `ACTIVE_LEVEL=0`.
- Clean press: drive `btn_in` 1→0 and hold → `btn_level` and `press_stb` rise 5 edges after the first low sample; `press_stb` lasts exactly one cycle.
- Bounce rejection: low 3 cycles, high 1, low 2, high 1, then steady low → no strobe during the bounce; `press_stb` 5 edges after the steady low begins.
- Long press: hold 20 cycles → `long_stb` 10 cycles after `press_stb`, `long_held=1`. On release, `release_stb` after 5 edges and `long_held=0`; only one `long_stb`.
- Short press: press held 8 cycles past commit, then release → `press_stb`, `release_stb`, no `long_stb`.
- Release/long race: release timed to commit on the `hold_cnt==9` cycle → `release_stb=1`, `long_stb` stays 0.
- Reset mid-press: `rstn=0` while in PRESSED with the button held → all outputs 0. After `rstn=1`, `press_stb` 6 edges later.

Source files
------------

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit input
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic s1;

  // Only s1 may sample the asynchronous input; q is the first safe point to read.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1 <= RESET_VAL;
      q  <= RESET_VAL;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - debounced push-button level with press/release/long-press strobes
module button_debouncer #(
  parameter int unsigned CLK_HZ        = 27000000,
  parameter int unsigned DEBOUNCE_MS   = 20,
  parameter int unsigned LONG_PRESS_MS = 1000,
  parameter logic        ACTIVE_LEVEL  = 1'b0
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_in,
  output logic btn_level,
  output logic press_stb,
  output logic release_stb,
  output logic long_stb,
  output logic long_held
);

  localparam int unsigned DEB_PROD  = CLK_HZ / 1000 * DEBOUNCE_MS;
  localparam int unsigned LONG_PROD = CLK_HZ / 1000 * LONG_PRESS_MS;
  localparam logic [31:0] DEB_TC    = (DEB_PROD == 0) ? 32'd1 : 32'(DEB_PROD);
  localparam logic [31:0] LONG_TC   = (LONG_PROD == 0) ? 32'd1 : 32'(LONG_PROD);

  typedef enum logic [1:0] {
    ST_RELEASED = 2'd0,
    ST_PRESSED  = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  logic        s2;
  logic        p;
  logic        commit;
  logic [31:0] deb_cnt;
  logic [31:0] hold_cnt, hold_d;
  state_t      state, state_d;
  logic        press_d, release_d, long_d, held_d;

  sync_2ff #(.RESET_VAL(~ACTIVE_LEVEL)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (btn_in),
    .q    (s2)
  );

  assign p      = (s2 == ACTIVE_LEVEL);
  assign commit = (p != btn_level) && (deb_cnt == DEB_TC - 32'd1);

  // Any cycle agreeing with the current level restarts the count.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      deb_cnt   <= 32'd0;
      btn_level <= 1'b0;
    end else if (p == btn_level) begin
      deb_cnt <= 32'd0;
    end else if (commit) begin
      btn_level <= p;
      deb_cnt   <= 32'd0;
    end else begin
      deb_cnt <= deb_cnt + 32'd1;
    end
  end

  // Release is tested before the long-press threshold so it wins a same-cycle race.
  always_comb begin
    state_d   = state;
    hold_d    = hold_cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    held_d    = long_held;
    case (state)
      ST_RELEASED: begin
        if (commit && p) begin
          state_d = ST_PRESSED;
          press_d = 1'b1;
          hold_d  = 32'd0;
        end
      end
      ST_PRESSED: begin
        if (commit && !p) begin
          state_d   = ST_RELEASED;
          release_d = 1'b1;
        end else if (hold_cnt == LONG_TC - 32'd1) begin
          state_d = ST_HELD;
          long_d  = 1'b1;
          held_d  = 1'b1;
        end else begin
          hold_d = hold_cnt + 32'd1;
        end
      end
      ST_HELD: begin
        if (commit && !p) begin
          state_d   = ST_RELEASED;
          release_d = 1'b1;
          held_d    = 1'b0;
        end
      end
      default: state_d = ST_RELEASED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= ST_RELEASED;
      hold_cnt    <= 32'd0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
      long_stb    <= 1'b0;
      long_held   <= 1'b0;
    end else begin
      state       <= state_d;
      hold_cnt    <= hold_d;
      press_stb   <= press_d;
      release_stb <= release_d;
      long_stb    <= long_d;
      long_held   <= held_d;
    end
  end

endmodule

// File: tb/tb_button_debouncer.sv
// tb/tb_button_debouncer.sv - directed self-checking bench for button_debouncer
module tb_button_debouncer;

  logic clk = 1'b0;
  logic rstn;
  logic btn_in;
  logic btn_level, press_stb, release_stb, long_stb, long_held;
  int   checks = 0;
  int   errors = 0;

  button_debouncer #(
    .CLK_HZ        (1000),
    .DEBOUNCE_MS   (4),
    .LONG_PRESS_MS (10),
    .ACTIVE_LEVEL  (1'b0)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .press_stb   (press_stb),
    .release_stb (release_stb),
    .long_stb    (long_stb),
    .long_held   (long_held)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive btn_in, then count edges until the chosen strobe (bounded).
  task automatic drive_and_count(input logic lvl, input bit want_press, output int n);
    btn_in = lvl;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if ((want_press && press_stb) || (!want_press && release_stb)) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn   = 1'b0;
    btn_in = 1'b1;
    step();
    step();
    checks++;
    if ({btn_level, press_stb, release_stb, long_stb, long_held} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b want=00000",
               {btn_level, press_stb, release_stb, long_stb, long_held});
    end
    rstn = 1'b1;
    repeat (3) step();
  endtask

  task automatic test_clean_press();
    int n;
    drive_and_count(1'b0, 1'b1, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL clean_press_latency got=%0d want=6", n); end
    checks++;
    if (btn_level !== 1'b1) begin errors++; $display("FAIL clean_press_level got=%b want=1", btn_level); end
    step();
    checks++;
    if (press_stb !== 1'b0) begin errors++; $display("FAIL clean_press_width got=%b want=0", press_stb); end
    drive_and_count(1'b1, 1'b0, n);
    checks++;
    if (n !== 6 || btn_level !== 1'b0) begin
      errors++; $display("FAIL clean_release got=%0d/%b want=6/0", n, btn_level);
    end
    repeat (2) step();
  endtask

  task automatic test_bounce();
    logic pat [7];
    int   n;
    int   bad = 0;
    pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 7; i++) begin
      btn_in = pat[i];
      step();
      if (press_stb || btn_level) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL bounce_glitch got=%0d want=0", bad); end
    drive_and_count(1'b0, 1'b1, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL bounce_press_latency got=%0d want=6", n); end
    drive_and_count(1'b1, 1'b0, n);
    repeat (2) step();
  endtask

  task automatic test_long_press();
    int n;
    int longs = 0;
    int long_at = 0;
    drive_and_count(1'b0, 1'b1, n);
    for (int i = 1; i <= 20; i++) begin
      step();
      if (long_stb) begin
        longs++;
        if (long_at == 0) long_at = i;
      end
    end
    checks++;
    if (long_at !== 10) begin errors++; $display("FAIL long_latency got=%0d want=10", long_at); end
    checks++;
    if (long_held !== 1'b1) begin errors++; $display("FAIL long_held_set got=%b want=1", long_held); end
    btn_in = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (long_stb) longs++;
      if (release_stb) begin n = i; break; end
    end
    checks++;
    if (n !== 6 || long_held !== 1'b0) begin
      errors++; $display("FAIL long_release got=%0d/%b want=6/0", n, long_held);
    end
    checks++;
    if (longs !== 1) begin errors++; $display("FAIL long_count got=%0d want=1", longs); end
    repeat (2) step();
  endtask

  // Release raw input `hold` edges after press_stb; returns edges from press to release_stb.
  task automatic press_then_release(input int hold, output int rel_at, output int longs);
    int n;
    longs  = 0;
    rel_at = 0;
    drive_and_count(1'b0, 1'b1, n);
    repeat (hold) begin
      step();
      if (long_stb) longs++;
    end
    btn_in = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (long_stb) longs++;
      if (release_stb) begin rel_at = hold + i; break; end
    end
    repeat (3) begin
      step();
      if (long_stb) longs++;
    end
  endtask

  task automatic test_short_press();
    int rel_at, longs;
    press_then_release(2, rel_at, longs);
    checks++;
    if (rel_at !== 8) begin errors++; $display("FAIL short_release got=%0d want=8", rel_at); end
    checks++;
    if (longs !== 0) begin errors++; $display("FAIL short_no_long got=%0d want=0", longs); end
  endtask

  task automatic test_race();
    int rel_at, longs;
    press_then_release(4, rel_at, longs);
    checks++;
    if (rel_at !== 10) begin errors++; $display("FAIL race_release got=%0d want=10", rel_at); end
    checks++;
    if (longs !== 0 || long_held !== 1'b0) begin
      errors++; $display("FAIL race_no_long got=%0d/%b want=0/0", longs, long_held);
    end
  endtask

  task automatic test_reset_mid_press();
    int n;
    drive_and_count(1'b0, 1'b1, n);
    repeat (3) step();
    rstn = 1'b0;
    step();
    checks++;
    if ({btn_level, press_stb, release_stb, long_stb, long_held} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_outputs got=%b want=00000",
               {btn_level, press_stb, release_stb, long_stb, long_held});
    end
    step();
    rstn = 1'b1;
    drive_and_count(1'b0, 1'b1, n);
    checks++;
    if (n !== 6) begin errors++; $display("FAIL midreset_repress got=%0d want=6", n); end
    drive_and_count(1'b1, 1'b0, n);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_long_press();
    test_short_press();
    test_race();
    test_reset_mid_press();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
